// File: rtl/cam_pkg.sv
// Shared types and defaults for the camera frame-buffer write path.
// Image geometry defaults, RGB444 pixel type and address-width helper.
package cam_pkg;

  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;
  localparam int PIX_W     = 12;

  typedef logic [PIX_W-1:0] rgb444_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  function automatic int addr_w(input int w, input int h);
    return $clog2(w * h);
  endfunction

endpackage

// File: rtl/fb_xy_cnt.sv
// Raster x/y position counters with line wrap and last-pixel flag.
// A clear restarts at (0,0) in the same cycle, so a pixel may count with it.
module fb_xy_cnt #(
  parameter int W  = 640,
  parameter int H  = 480,
  parameter int XW = (W > 1) ? $clog2(W) : 1,
  parameter int YW = (H > 1) ? $clog2(H) : 1
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_last
);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          x_end;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  always_comb begin
    o_x    = i_clr ? '0 : x_q;
    o_y    = i_clr ? '0 : y_q;
    x_end  = (o_x == XW'(W - 1));
    o_last = x_end && (o_y == YW'(H - 1));
    x_d    = o_x;
    y_d    = o_y;
    if (i_inc) begin
      if (x_end) begin
        x_d = '0;
        y_d = o_last ? '0 : o_y + YW'(1);
      end else begin
        x_d = o_x + XW'(1);
      end
    end
  end

endmodule

// File: rtl/cam_fb_writer.sv
// Camera pixel stream to linear frame-buffer BRAM writes, pclk domain.
// Define FB_DECIM2_EN to store a 2x2-decimated frame instead.
module cam_fb_writer
  import cam_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = addr_w(IMG_W, IMG_H),
  parameter int DATA_W = PIX_W
) (
  input  logic              i_pclk,
  input  logic              i_rstn,
  input  logic              i_frame_en,
  input  logic              i_sof,
  input  logic              i_wr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_bram_we,
  output logic [ADDR_W-1:0] o_bram_addr,
  output logic [DATA_W-1:0] o_bram_wdata,
  output logic              o_frame_done,
  output logic              o_busy,
  output logic              o_short,
  output logic              o_ovf
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] cnt_q, cnt_d, cnt_cur;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q, done_q, short_q, ovf_q;

  logic          start, in_frame, acc, keep, last, done;
  logic          short_set, ovf_set;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          unused_xy;

  fb_xy_cnt #(
    .W (IMG_W),
    .H (IMG_H),
    .XW(XW),
    .YW(YW)
  ) u_xy (
    .i_clk (i_pclk),
    .i_rstn(i_rstn),
    .i_clr (i_sof),
    .i_inc (acc),
    .o_x   (x),
    .o_y   (y),
    .o_last(last)
  );

  // Full raster position is only needed by decimation and the VGA reuse.
  assign unused_xy = ^{x, y};

  always_ff @(posedge i_pclk or negedge i_rstn) begin
    if (!i_rstn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_sof) state_d = i_frame_en ? ACTIVE : IDLE;
    if (done)  state_d = IDLE;
  end

  always_comb begin
    start     = i_sof & i_frame_en;
    in_frame  = start | ((state_q == ACTIVE) & ~i_sof);
    acc       = i_wr & in_frame;
`ifdef FB_DECIM2_EN
    keep      = acc & ~x[0] & ~y[0];
`else
    keep      = acc;
`endif
    done      = acc & last;
    short_set = (state_q == ACTIVE) & i_sof;
    ovf_set   = (state_q == IDLE) & i_wr & i_frame_en & ~i_sof;
    cnt_cur   = i_sof ? '0 : cnt_q;
    if (done)      cnt_d = '0;
    else if (keep) cnt_d = cnt_cur + ADDR_W'(1);
    else           cnt_d = cnt_cur;
  end

  always_ff @(posedge i_pclk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      short_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      we_q    <= keep;
      done_q  <= done;
      short_q <= short_q | short_set;
      ovf_q   <= ovf_q | ovf_set;
      if (keep) begin
        waddr_q <= cnt_cur;
        wdata_q <= i_wdata;
      end
    end
  end

  // Busy covers the final registered write that lands after leaving ACTIVE.
  assign o_busy       = (state_q == ACTIVE) | done_q;
  assign o_bram_we    = we_q;
  assign o_bram_addr  = waddr_q;
  assign o_bram_wdata = wdata_q;
  assign o_frame_done = done_q;
  assign o_short      = short_q;
  assign o_ovf        = ovf_q;

endmodule
